// File: rtl/dice_pkg.sv
// Shared types and constants for the craps scoring controller.
package dice_pkg;

  typedef logic [3:0] sum_t;

  typedef enum logic [1:0] {
    COME_OUT,
    POINT,
    WIN,
    LOSE
  } state_t;

  localparam sum_t SUM_MIN    = 4'd2;
  localparam sum_t SUM_MAX    = 4'd12;
  localparam sum_t NATURAL_7  = 4'd7;
  localparam sum_t NATURAL_11 = 4'd11;
  localparam sum_t CRAPS_2    = 4'd2;
  localparam sum_t CRAPS_3    = 4'd3;
  localparam sum_t CRAPS_12   = 4'd12;
  localparam sum_t SEVEN_OUT  = 4'd7;

  function automatic logic sum_legal(input sum_t s);
    return (s >= SUM_MIN) && (s <= SUM_MAX);
  endfunction

endpackage

// File: rtl/roll_edge_det.sv
// Registered falling-edge detector on the roll button level.
module roll_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic roll,
  output logic rel
);

  logic roll_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) roll_q <= 1'b0;
    else       roll_q <= roll;
  end

  assign rel = roll_q & ~roll;

endmodule

// File: rtl/dice_game.sv
// Craps come-out/point state machine with registered win/lose/point/count outputs.
module dice_game
  import dice_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             roll,
  input  logic [3:0]       sum,
  input  logic             new_game,
  output logic             win,
  output logic             lose,
  output logic [3:0]       point,
  output logic [3:0]       last_sum,
  output logic             roll_done,
  output logic             bad_sum,
  output logic [CNT_W-1:0] roll_count
);

  state_t state;
  state_t eval_next;
  logic   rel;
  logic   playing;

  roll_edge_det u_edge (
    .clk   (clk),
    .reset (reset),
    .roll  (roll),
    .rel   (rel)
  );

  assign playing = (state == COME_OUT) || (state == POINT);

  // Classifier: outcome of a legal roll from the current state.
  // NOTE: the default assignment up front keeps this block free of inferred latches.
  always_comb begin
    eval_next = state;
    case (state)
      COME_OUT: begin
        if (sum == NATURAL_7 || sum == NATURAL_11)
          eval_next = WIN;
        else if (sum == CRAPS_2 || sum == CRAPS_3 || sum == CRAPS_12)
          eval_next = LOSE;
        else
          eval_next = POINT;
      end
      POINT: begin
        if (sum == point)          eval_next = WIN;
        else if (sum == SEVEN_OUT) eval_next = LOSE;
      end
      default: eval_next = state;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= COME_OUT;
      win        <= 1'b0;
      lose       <= 1'b0;
      point      <= '0;
      last_sum   <= '0;
      roll_done  <= 1'b0;
      bad_sum    <= 1'b0;
      roll_count <= '0;
    end else begin
      roll_done <= 1'b0;
      bad_sum   <= 1'b0;
      if (new_game) begin
        state      <= COME_OUT;
        win        <= 1'b0;
        lose       <= 1'b0;
        point      <= '0;
        last_sum   <= '0;
        roll_count <= '0;
      end else if (rel && playing) begin
        if (!sum_legal(sum)) begin
          bad_sum <= 1'b1;
        end else begin
          roll_done <= 1'b1;
          last_sum  <= sum;
          if (roll_count != '1) roll_count <= roll_count + 1'b1;
          state <= eval_next;
          win   <= (eval_next == WIN);
          lose  <= (eval_next == LOSE);
          if (state == COME_OUT && eval_next == POINT) point <= sum;
        end
      end
    end
  end

endmodule

// File: tb/tb_dice_game.sv
// Self-checking bench for dice_game against a rule-level craps model.
module tb_dice_game;

  localparam int CNT_W = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             roll;
  logic [3:0]       sum;
  logic             new_game;
  logic             win;
  logic             lose;
  logic [3:0]       point;
  logic [3:0]       last_sum;
  logic             roll_done;
  logic             bad_sum;
  logic [CNT_W-1:0] roll_count;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: game result (0 playing, 1 won, 2 lost), point (0 = none).
  int m_res, m_point, m_last, m_count;
  bit m_done, m_bad;

  dice_game #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .roll       (roll),
    .sum        (sum),
    .new_game   (new_game),
    .win        (win),
    .lose       (lose),
    .point      (point),
    .last_sum   (last_sum),
    .roll_done  (roll_done),
    .bad_sum    (bad_sum),
    .roll_count (roll_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_res = 0; m_point = 0; m_last = 0; m_count = 0; m_done = 0; m_bad = 0;
  endtask

  task automatic model_release(input int s, input bit ng);
    m_done = 0;
    m_bad  = 0;
    if (ng) begin
      model_clear();
    end else if (m_res == 0) begin
      if (s < 2 || s > 12) begin
        m_bad = 1;
      end else begin
        m_done = 1;
        m_last = s;
        if (m_count < CNT_MAX) m_count++;
        if (m_point == 0) begin
          if (s == 7 || s == 11)               m_res = 1;
          else if (s == 2 || s == 3 || s == 12) m_res = 2;
          else                                  m_point = s;
        end else if (s == m_point) begin
          m_res = 1;
        end else if (s == 7) begin
          m_res = 2;
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".win"},        int'(win),        int'(m_res == 1));
    chk({tag, ".lose"},       int'(lose),       int'(m_res == 2));
    chk({tag, ".point"},      int'(point),      m_point);
    chk({tag, ".last_sum"},   int'(last_sum),   m_last);
    chk({tag, ".roll_done"},  int'(roll_done),  int'(m_done));
    chk({tag, ".bad_sum"},    int'(bad_sum),    int'(m_bad));
    chk({tag, ".roll_count"}, int'(roll_count), m_count);
  endtask

  // Hold roll for 1..3 cycles with a scrambled sum, then release with s.
  task automatic do_roll(input string tag, input int s, input bit ng);
    int hold;
    hold = $urandom_range(1, 3);
    for (int i = 0; i < hold; i++) begin
      roll = 1'b1;
      sum  = 4'($urandom);
      step();
      m_done = 0;
      m_bad  = 0;
      check_all({tag, ".hold"});
    end
    roll     = 1'b0;
    sum      = 4'(s);
    new_game = ng;
    step();
    new_game = 1'b0;
    model_release(s, ng);
    check_all(tag);
  endtask

  task automatic do_new_game(input string tag);
    new_game = 1'b1;
    step();
    new_game = 1'b0;
    model_release(0, 1'b1);
    check_all(tag);
  endtask

  initial begin
    int filler [9] = '{2, 3, 5, 6, 8, 9, 10, 11, 12};

    reset = 1'b1; roll = 1'b0; sum = '0; new_game = 1'b0;
    step();
    step();
    reset = 1'b0;
    model_clear();
    check_all("reset");

    do_roll("natural7", 7, 1'b0);

    do_new_game("ng1");
    do_roll("craps12", 12, 1'b0);
    do_roll("after_lose", 7, 1'b0);

    do_new_game("ng2");
    do_roll("pt6", 6, 1'b0);
    do_roll("pt6_r8", 8, 1'b0);
    do_roll("pt6_win", 6, 1'b0);

    do_new_game("ng3");
    do_roll("pt4", 4, 1'b0);
    do_roll("seven_out", 7, 1'b0);
    do_new_game("restart");

    do_roll("pt9", 9, 1'b0);
    do_roll("bad13", 13, 1'b0);
    do_roll("bad0", 0, 1'b0);

    do_new_game("ng4");
    do_roll("ng_vs_rel", 7, 1'b1);

    do_roll("pt5", 5, 1'b0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    model_clear();
    check_all("reset_mid");

    reset = 1'b1; roll = 1'b1;
    step();
    reset = 1'b0; roll = 1'b0; sum = 4'd7;
    step();
    model_clear();
    check_all("roll_in_reset");

    do_roll("sat_pt4", 4, 1'b0);
    for (int i = 0; i < CNT_MAX + 2; i++)
      do_roll("sat", filler[$urandom_range(0, 8)], 1'b0);

    do_new_game("ng5");
    for (int i = 0; i < 300; i++)
      do_roll("rand", $urandom_range(0, 15), ($urandom_range(0, 7) == 0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
